// File: rtl/snow64_vector_alu_sequencer.sv
// ----------------------------------------------------------------------------
// snow64_vector_alu_sequencer
//
// Multi-cycle sequencer for a 256-bit vector arithmetic-shift-right /
// set-less-than operation. One 64-bit chunk is computed per beat on a single
// 64-bit datapath slice. Inside a chunk, elements of 8/16/32/64 bits are
// handled in parallel. Only one operation is in flight at a time.
//
// Ports:
//   clk            in   1    clock, rising edge
//   rst            in   1    asynchronous, active-high reset
//   in_req_valid   in   1    request present
//   out_req_ready  out  1    sequencer can accept a request (IDLE only)
//   in_op          in   2    0=ASR, 1=SLTU, 2=SLTS, 3=reserved (result 0)
//   in_int_size    in   2    element width: 0=8, 1=16, 2=32, 3=64 bits
//   in_a           in   256  operand A (value to shift / left comparand)
//   in_b           in   256  operand B (shift amount / right comparand)
//   in_chunk_mask  in   4    chunks to process (optional, see below)
//   out_rsp_valid  out  1    result valid (DONE state)
//   in_rsp_ready   in   1    consumer accepts result
//   out_data       out  256  result register
//   out_busy       out  1    operation in flight
//
// Optional feature macro: SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
//   Adds in_chunk_mask. Only chunks whose mask bit is set are computed, in
//   ascending order; the others keep the captured A chunk. A zero mask goes
//   straight from IDLE to DONE with result = A.
// ----------------------------------------------------------------------------
module snow64_vector_alu_sequencer #(
    parameter int WIDTH__VECTOR = 256,
    parameter int WIDTH__CHUNK  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_req_valid,
    output logic                     out_req_ready,
    input  logic [1:0]               in_op,
    input  logic [1:0]               in_int_size,
    input  logic [WIDTH__VECTOR-1:0] in_a,
    input  logic [WIDTH__VECTOR-1:0] in_b,
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
    input  logic [3:0]               in_chunk_mask,
`endif
    output logic                     out_rsp_valid,
    input  logic                     in_rsp_ready,
    output logic [WIDTH__VECTOR-1:0] out_data,
    output logic                     out_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [1:0] OP_ASR  = 2'd0;
    localparam logic [1:0] OP_SLTU = 2'd1;
    localparam logic [1:0] OP_SLTS = 2'd2;

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [1:0]               r_op;
    logic [1:0]               r_size;
    logic [WIDTH__VECTOR-1:0] r_a;
    logic [WIDTH__VECTOR-1:0] r_b;
    logic [WIDTH__VECTOR-1:0] r_result;
    logic [1:0]               w_idx;
    logic                     w_lastBeat;
    logic [WIDTH__CHUNK-1:0]  w_chunkA;
    logic [WIDTH__CHUNK-1:0]  w_chunkB;
    logic [WIDTH__CHUNK-1:0]  w_chunkResult;

    // One element of width (msb+1) held in the low bits of a 64-bit word.
    // Operand bits above the element are masked off, so callers may pass
    // unmasked data. The result sits in the low bits, upper bits zero.
    function automatic logic [WIDTH__CHUNK-1:0] f_elem(
        input logic [WIDTH__CHUNK-1:0] a,
        input logic [WIDTH__CHUNK-1:0] b,
        input logic [1:0]              op,
        input logic [5:0]              msb
    );
        logic [WIDTH__CHUNK-1:0] mask;
        logic [WIDTH__CHUNK-1:0] ua;
        logic [WIDTH__CHUNK-1:0] ub;
        logic [WIDTH__CHUNK-1:0] sa;
        logic [WIDTH__CHUNK-1:0] diff;
        logic [WIDTH__CHUNK-1:0] res;
        logic                    aMsb;
        logic                    bMsb;
        logic                    dMsb;
        logic                    ovf;
        // Double shift so a 64-bit element wraps to zero and the mask
        // becomes all ones after the subtract.
        mask = ((64'd1 << msb) << 1) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        aMsb = ua[msb];
        bMsb = ub[msb];
        // Sign-extend A to 64 bits so a 64-bit arithmetic shift does the work.
        sa   = ua | (aMsb ? ~mask : 64'd0);
        diff = (ua - ub) & mask;
        dMsb = diff[msb];
        ovf  = (aMsb ^ bMsb) & (aMsb ^ dMsb);
        res  = '0;
        case (op)
            OP_ASR: begin
                // Amount is the whole unsigned element; anything >= W
                // saturates to a sign fill.
                if (ub > {58'd0, msb}) begin
                    res = aMsb ? mask : 64'd0;
                end else begin
                    res = 64'($signed(sa) >>> ub[5:0]) & mask;
                end
            end
            OP_SLTU: res = {63'd0, (ua < ub)};
            OP_SLTS: res = {63'd0, (dMsb ^ ovf)};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Full 64-bit chunk: split into elements according to the size code.
    function automatic logic [WIDTH__CHUNK-1:0] f_chunk(
        input logic [WIDTH__CHUNK-1:0] a,
        input logic [WIDTH__CHUNK-1:0] b,
        input logic [1:0]              op,
        input logic [1:0]              size
    );
        logic [WIDTH__CHUNK-1:0] res;
        logic [WIDTH__CHUNK-1:0] e;
        res = '0;
        e   = '0;
        case (size)
            2'd0: begin
                for (int i = 0; i < 8; i++) begin
                    e = f_elem({56'd0, a[8*i +: 8]}, {56'd0, b[8*i +: 8]}, op, 6'd7);
                    res[8*i +: 8] = e[7:0];
                end
            end
            2'd1: begin
                for (int i = 0; i < 4; i++) begin
                    e = f_elem({48'd0, a[16*i +: 16]}, {48'd0, b[16*i +: 16]}, op, 6'd15);
                    res[16*i +: 16] = e[15:0];
                end
            end
            2'd2: begin
                for (int i = 0; i < 2; i++) begin
                    e = f_elem({32'd0, a[32*i +: 32]}, {32'd0, b[32*i +: 32]}, op, 6'd31);
                    res[32*i +: 32] = e[31:0];
                end
            end
            default: res = f_elem(a, b, op, 6'd63);
        endcase
        return res;
    endfunction

    // Chunk selection: a plain beat counter in the default build, or the
    // lowest still-pending mask bit when chunk masking is enabled.
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
    logic [3:0] r_pend;
    logic [3:0] w_pendNext;

    always_comb begin
        w_idx = 2'd0;
        if (r_pend[0]) begin
            w_idx = 2'd0;
        end else if (r_pend[1]) begin
            w_idx = 2'd1;
        end else if (r_pend[2]) begin
            w_idx = 2'd2;
        end else if (r_pend[3]) begin
            w_idx = 2'd3;
        end
    end

    assign w_pendNext = r_pend & ~(4'b0001 << w_idx);
    assign w_lastBeat = (w_pendNext == 4'd0);
`else
    logic [1:0] r_chunkIdx;

    assign w_idx      = r_chunkIdx;
    assign w_lastBeat = (r_chunkIdx == 2'd3);
`endif

    assign w_chunkA      = r_a[{w_idx, 6'd0} +: 64];
    assign w_chunkB      = r_b[{w_idx, 6'd0} +: 64];
    assign w_chunkResult = f_chunk(w_chunkA, w_chunkB, r_op, r_size);
    assign out_data      = r_result;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake outputs. Ready is only offered in IDLE, so a
    // request can never be accepted in the same cycle a response retires.
    always_comb begin
        w_stateNext   = r_state;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        out_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                out_req_ready = 1'b1;
                out_busy      = 1'b0;
                if (in_req_valid) begin
                    w_stateNext = ST_RUN;
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
                    if (in_chunk_mask == 4'd0) begin
                        w_stateNext = ST_DONE;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (w_lastBeat) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                out_rsp_valid = 1'b1;
                if (in_rsp_ready) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one chunk written into the result per
    // RUN beat. The result register is untouched in DONE, keeping out_data
    // stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= 2'd0;
            r_size   <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
            r_pend   <= 4'd0;
`else
            r_chunkIdx <= 2'd0;
`endif
        end else begin
            if (r_state == ST_IDLE && in_req_valid) begin
                r_op   <= in_op;
                r_size <= in_int_size;
                r_a    <= in_a;
                r_b    <= in_b;
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
                r_pend   <= in_chunk_mask;
                r_result <= in_a;
`else
                r_chunkIdx <= 2'd0;
`endif
            end else if (r_state == ST_RUN) begin
                r_result[{w_idx, 6'd0} +: 64] <= w_chunkResult;
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
                r_pend <= w_pendNext;
`else
                r_chunkIdx <= r_chunkIdx + 2'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_snow64_vector_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_snow64_vector_alu_sequencer
//
// Table of hand-computed vectors plus a few random operations checked
// against a behavioural element model. Expected results go into a queue when
// a request is accepted and are popped when the response is consumed. Extra
// hand-written sequences cover backpressure and reset during RUN.
// ----------------------------------------------------------------------------
module tb_snow64_vector_alu_sequencer;

    logic         clk;
    logic         rst;
    logic         in_req_valid;
    logic         out_req_ready;
    logic [1:0]   in_op;
    logic [1:0]   in_int_size;
    logic [255:0] in_a;
    logic [255:0] in_b;
    logic         out_rsp_valid;
    logic         in_rsp_ready;
    logic [255:0] out_data;
    logic         out_busy;
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
    logic [3:0]   in_chunk_mask;
`endif

    int nChecks = 0;
    int nFails  = 0;
    logic [255:0] scoreboard[$];

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [1:0]   size;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs[11];

    snow64_vector_alu_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .in_req_valid  (in_req_valid),
        .out_req_ready (out_req_ready),
        .in_op         (in_op),
        .in_int_size   (in_int_size),
        .in_a          (in_a),
        .in_b          (in_b),
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
        .in_chunk_mask (in_chunk_mask),
`endif
        .out_rsp_valid (out_rsp_valid),
        .in_rsp_ready  (in_rsp_ready),
        .out_data      (out_data),
        .out_busy      (out_busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural reference: walks every element of the 256-bit vector,
    // shifts one bit at a time for ASR and compares sign-extended values.
    function automatic logic [255:0] modelOp(input logic [1:0] op, input logic [1:0] size,
                                             input logic [255:0] a, input logic [255:0] b);
        logic [255:0] res;
        logic [63:0]  mask;
        logic [63:0]  ea;
        logic [63:0]  eb;
        logic [63:0]  r;
        logic [63:0]  sa;
        logic [63:0]  sb;
        logic [63:0]  top;
        logic         sign;
        int           w;
        w    = 8 << size;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        top  = 64'd1 << (w - 1);
        res  = '0;
        for (int i = 0; i < 256 / w; i++) begin
            ea   = 64'(a >> (i * w)) & mask;
            eb   = 64'(b >> (i * w)) & mask;
            sign = ((ea & top) != 0);
            sa   = sign ? (ea | ~mask) : ea;
            sb   = ((eb & top) != 0) ? (eb | ~mask) : eb;
            r    = '0;
            case (op)
                2'd0: begin
                    if (eb >= 64'(w)) begin
                        r = sign ? mask : 64'd0;
                    end else begin
                        r = ea;
                        for (int s = 0; s < int'(eb); s++) begin
                            r = (r >> 1) | (sign ? top : 64'd0);
                        end
                    end
                end
                2'd1: r = (ea < eb) ? 64'd1 : 64'd0;
                2'd2: r = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
                default: r = '0;
            endcase
            res = res | (256'(r) << (i * w));
        end
        return res;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) begin
            v[32*i +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic checkVec(input string name, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Drive one request, push its expected result at the accept edge, then
    // wait for out_rsp_valid and check the latency. With holdValid set the
    // request line stays asserted (with different operands) afterwards, so a
    // wrongly accepted second request would corrupt the result.
    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [1:0] size,
                                 input logic [255:0] a, input logic [255:0] b,
                                 input logic [255:0] exp, input bit holdValid);
        int waitCnt;
        int lat;
        waitCnt = 0;
        while (!out_req_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkBit({name, "_req_ready"}, out_req_ready, 1'b1);
        in_req_valid = 1'b1;
        in_op        = op;
        in_int_size  = size;
        in_a         = a;
        in_b         = b;
        @(posedge clk); #1;
        scoreboard.push_back(exp);
        in_req_valid = holdValid;
        in_op        = ~op;
        in_int_size  = ~size;
        in_a         = ~a;
        in_b         = rand256();
        lat = 0;
        while (!out_rsp_valid && lat < 20) begin
            if (lat == 1) begin
                checkBit({name, "_busy_run"}, out_busy, 1'b1);
                checkBit({name, "_ready_run"}, out_req_ready, 1'b0);
            end
            @(posedge clk); #1;
            lat++;
        end
        checkInt({name, "_latency"}, lat, 4);
    endtask

    // Consume the response: check DONE outputs, pop the scoreboard, give one
    // cycle of in_rsp_ready and check the return to IDLE.
    task automatic checkOutput(input string name);
        logic [255:0] exp;
        checkBit({name, "_rsp_valid"}, out_rsp_valid, 1'b1);
        checkBit({name, "_ready_done"}, out_req_ready, 1'b0);
        if (scoreboard.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s_scoreboard: got empty queue required one entry", name);
        end else begin
            exp = scoreboard.pop_front();
            checkVec({name, "_data"}, out_data, exp);
        end
        in_rsp_ready = 1'b1;
        @(posedge clk); #1;
        in_rsp_ready = 1'b0;
        checkBit({name, "_valid_after"}, out_rsp_valid, 1'b0);
        checkBit({name, "_ready_after"}, out_req_ready, 1'b1);
    endtask

    initial begin
        logic [255:0] snap;
        logic [255:0] ra;
        logic [255:0] rb;
        logic [1:0]   rop;
        logic [1:0]   rsize;

        vecs[0]  = '{"asr8_basic", 2'd0, 2'd0,
                     {64'h0, 64'h0, 64'h40, 64'h8080_8080_8080_8080},
                     {64'h0, 64'h0, 64'h02, 64'h0101_0101_0101_0101},
                     {64'h0, 64'h0, 64'h10, 64'hC0C0_C0C0_C0C0_C0C0}};
        vecs[1]  = '{"asr8_sat", 2'd0, 2'd0,
                     {64'h0, 64'h0, 64'h0, 64'h7090},
                     {64'h0, 64'h0, 64'h0, 64'h0909},
                     {64'h0, 64'h0, 64'h0, 64'h00FF}};
        vecs[2]  = '{"asr64", 2'd0, 2'd3,
                     {64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000,
                      64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000},
                     {64'd1, 64'd0, 64'd64, 64'd63},
                     {64'h2000_0000_0000_0000, 64'h8000_0000_0000_0000,
                      64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}};
        vecs[3]  = '{"slts64", 2'd2, 2'd3,
                     {64'h0, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF},
                     {64'h0, 64'h0, 64'h2, 64'h0},
                     {64'h0, 64'h0, 64'h1, 64'h1}};
        vecs[4]  = '{"sltu64", 2'd1, 2'd3,
                     {64'h0, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF},
                     {64'h0, 64'h0, 64'h2, 64'h0},
                     {64'h0, 64'h0, 64'h1, 64'h0}};
        vecs[5]  = '{"slts16", 2'd2, 2'd1,
                     {64'h0, 64'h0, 64'h0, 64'h8000_7FFF},
                     {64'h0, 64'h0, 64'h0, 64'h7FFF_8000},
                     {64'h0, 64'h0, 64'h0, 64'h0001_0000}};
        vecs[6]  = '{"sltu16", 2'd1, 2'd1,
                     {64'h0, 64'h0, 64'h0, 64'h8000_7FFF},
                     {64'h0, 64'h0, 64'h0, 64'h7FFF_8000},
                     {64'h0, 64'h0, 64'h0, 64'h0000_0001}};
        vecs[7]  = '{"asr32", 2'd0, 2'd2,
                     {64'h0, 64'h1234_5678_F000_0000, 64'h0, 64'h0},
                     {64'h0, 64'h0000_0020_0000_0004, 64'h0, 64'h0},
                     {64'h0, 64'h0000_0000_FF00_0000, 64'h0, 64'h0}};
        vecs[8]  = '{"slts8", 2'd2, 2'd0,
                     {64'h8001, 64'h0, 64'h0, 64'h0},
                     {64'h7FFF, 64'h0, 64'h0, 64'h0},
                     {64'h0100, 64'h0, 64'h0, 64'h0}};
        vecs[9]  = '{"sltu8", 2'd1, 2'd0,
                     {64'h8001, 64'h0, 64'h0, 64'h0},
                     {64'h7FFF, 64'h0, 64'h0, 64'h0},
                     {64'h0001, 64'h0, 64'h0, 64'h0}};
        vecs[10] = '{"reserved", 2'd3, 2'd0,
                     {4{64'hDEAD_BEEF_0123_4567}},
                     {4{64'h89AB_CDEF_FEDC_BA98}},
                     256'h0};

        rst          = 1'b1;
        in_req_valid = 1'b0;
        in_op        = 2'd0;
        in_int_size  = 2'd0;
        in_a         = '0;
        in_b         = '0;
        in_rsp_ready = 1'b0;
`ifdef SNOW64_VECTOR_ALU_SEQUENCER_CHUNK_MASK_EN
        in_chunk_mask = 4'b1111;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] reset state");
        checkBit("reset_req_ready", out_req_ready, 1'b1);
        checkBit("reset_rsp_valid", out_rsp_valid, 1'b0);
        checkBit("reset_busy", out_busy, 1'b0);
        checkVec("reset_data", out_data, 256'h0);

        $display("[TB] table vectors");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].size, vecs[i].a, vecs[i].b,
                          vecs[i].exp, 1'b0);
            checkOutput(vecs[i].name);
        end

        $display("[TB] random vectors against model");
        for (int i = 0; i < 6; i++) begin
            rop   = 2'($urandom_range(0, 2));
            rsize = 2'($urandom_range(0, 3));
            ra    = rand256();
            rb    = rand256();
            // Keep some ASR amounts small so real shifts occur.
            if (rop == 2'd0 && i[0]) begin
                rb = rb & {32{8'h07}};
            end
            applyStimulus("random", rop, rsize, ra, rb, modelOp(rop, rsize, ra, rb), 1'b0);
            checkOutput("random");
        end

        $display("[TB] backpressure and request during RUN/DONE");
        applyStimulus("bp", vecs[0].op, vecs[0].size, vecs[0].a, vecs[0].b, vecs[0].exp, 1'b1);
        snap = out_data;
        for (int c = 0; c < 10; c++) begin
            checkBit("bp_valid_hold", out_rsp_valid, 1'b1);
            checkBit("bp_ready_low", out_req_ready, 1'b0);
            checkVec("bp_data_stable", out_data, snap);
            @(posedge clk); #1;
        end
        in_req_valid = 1'b0;
        checkOutput("bp");
        checkBit("bp_idle_not_busy", out_busy, 1'b0);

        $display("[TB] reset during RUN");
        in_req_valid = 1'b1;
        in_op        = vecs[2].op;
        in_int_size  = vecs[2].size;
        in_a         = vecs[2].a;
        in_b         = vecs[2].b;
        @(posedge clk); #1;
        in_req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkBit("rstrun_rsp_valid", out_rsp_valid, 1'b0);
        checkBit("rstrun_req_ready", out_req_ready, 1'b1);
        checkBit("rstrun_busy", out_busy, 1'b0);
        checkVec("rstrun_data", out_data, 256'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkBit("rstrun_no_rsp", out_rsp_valid, 1'b0);
        applyStimulus("after_rst", vecs[3].op, vecs[3].size, vecs[3].a, vecs[3].b,
                      vecs[3].exp, 1'b0);
        checkOutput("after_rst");
        checkInt("scoreboard_drained", scoreboard.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
